// File: rtl/pulse_train_gen.sv
// Run-time configurable pulse generator: single pulse, N-pulse burst or continuous train,
// with start/stop handshake and busy/done/aborted status. All outputs are registered.
`timescale 1ns/1ps

module pulse_train_gen #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  high_len,
    input  logic [W-1:0]  low_len,
    input  logic [CW-1:0] count,
    output logic          signal,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_BURST = 2'b01;
    localparam logic [1:0] MODE_CONT  = 2'b10;

    state_t        state_q,     state_d;
    logic [1:0]    mode_q,      mode_d;
    logic [W-1:0]  high_q,      high_d;
    logic [W-1:0]  low_q,       low_d;
    logic [CW-1:0] count_q,     count_d;
    logic [W-1:0]  phase_q,     phase_d;
    logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          signal_q,    signal_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          aborted_q,   aborted_d;

    logic [W-1:0]  high_eff;
    logic [W-1:0]  low_eff;
    logic [CW-1:0] count_eff;
    logic [CW-1:0] pulse_inc;
    logic          phase_end;
    logic          last_pulse;

    // Zero-valued configuration is promoted to 1 so every phase lasts at least one cycle.
    assign high_eff  = (high_len == '0) ? W'(1)  : high_len;
    assign low_eff   = (low_len  == '0) ? W'(1)  : low_len;
    assign count_eff = (count    == '0) ? CW'(1) : count;

    assign pulse_inc = pulse_cnt_q + CW'(1);
    assign phase_end = (phase_q == '0);

    always_comb begin
        last_pulse = 1'b1;
        case (mode_q)
            MODE_BURST: last_pulse = (pulse_inc == count_q);
            MODE_CONT:  last_pulse = 1'b0;
            default:    last_pulse = 1'b1;
        endcase
    end

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        high_d      = high_q;
        low_d       = low_q;
        count_d     = count_q;
        phase_d     = phase_q;
        pulse_cnt_d = pulse_cnt_q;
        signal_d    = signal_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                signal_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    mode_d      = mode;
                    high_d      = high_eff;
                    low_d       = low_eff;
                    count_d     = count_eff;
                    phase_d     = high_eff - W'(1);
                    pulse_cnt_d = '0;
                    state_d     = ST_HIGH;
                    signal_d    = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_HIGH: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    signal_d  = 1'b0;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (phase_end) begin
                    pulse_cnt_d = pulse_inc;
                    signal_d    = 1'b0;
                    if (last_pulse) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        phase_d = low_q - W'(1);
                    end
                end else begin
                    phase_d = phase_q - W'(1);
                end
            end

            ST_LOW: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    signal_d  = 1'b0;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (phase_end) begin
                    state_d  = ST_HIGH;
                    signal_d = 1'b1;
                    phase_d  = high_q - W'(1);
                end else begin
                    phase_d = phase_q - W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                signal_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous and clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            high_q      <= '0;
            low_q       <= '0;
            count_q     <= '0;
            phase_q     <= '0;
            pulse_cnt_q <= '0;
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            high_q      <= high_d;
            low_q       <= low_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            pulse_cnt_q <= pulse_cnt_d;
            signal_q    <= signal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign signal    = signal_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: per-cycle expected outputs are queued with the stimulus
// and popped/compared one time unit after each rising edge.
`timescale 1ns/1ps

module tb_pulse_train_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] count;
    logic       signal;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] pulse_cnt;

    typedef struct packed {
        logic       sig;
        logic       busy;
        logic       done;
        logic       ab;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pulse_train_gen #(.W(8), .CW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .high_len  (high_len),
        .low_len   (low_len),
        .count     (count),
        .signal    (signal),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_signal"},    32'(signal),    32'(e.sig));
        check({tag, "_busy"},      32'(busy),      32'(e.busy));
        check({tag, "_done"},      32'(done),      32'(e.done));
        check({tag, "_aborted"},   32'(aborted),   32'(e.ab));
        check({tag, "_pulse_cnt"}, 32'(pulse_cnt), 32'(e.pc));
    endtask

    // Push the expectation for the next edge, advance one cycle, then pop and compare.
    task automatic step(input string tag, input logic s, input logic b, input logic d,
                        input logic a, input logic [7:0] pc);
        exp_t e;
        e.sig = s; e.busy = b; e.done = d; e.ab = a; e.pc = pc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed signal %0b expected entry", tag, signal);
        end else begin
            check_outputs(tag, sb.pop_front());
        end
    endtask

    task automatic check_now(input string tag, input logic [7:0] pc);
        exp_t e;
        e.sig = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.ab = 1'b0; e.pc = pc;
        check_outputs(tag, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
        high_len = '0; low_len = '0; count = '0;
        #1;
        check_now("reset", 8'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // single pulse, high_len=3
        mode = 2'b00; high_len = 8'd3; low_len = 8'd5; start = 1'b1;
        step("single", 1, 1, 0, 0, 8'd0);
        start = 1'b0;
        step("single", 1, 1, 0, 0, 8'd0);
        step("single", 1, 1, 0, 0, 8'd0);
        step("single_done", 0, 0, 1, 0, 8'd1);
        step("single_idle", 0, 0, 0, 0, 8'd1);

        // burst of 3, high 2 / low 2: 1,1,0,0,1,1,0,0,1,1 then done
        mode = 2'b01; high_len = 8'd2; low_len = 8'd2; count = 8'd3; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("burst", 1'((i % 4) < 2), 1, 0, 0, 8'((i + 2) / 4));
            start = 1'b0;
        end
        step("burst_done", 0, 0, 1, 0, 8'd3);
        step("burst_idle", 0, 0, 0, 0, 8'd3);

        // mode 11 behaves as single
        mode = 2'b11; high_len = 8'd1; start = 1'b1;
        step("mode3", 1, 1, 0, 0, 8'd0);
        start = 1'b0;
        step("mode3_done", 0, 0, 1, 0, 8'd1);

        // continuous 1/1, stop sampled at the end of the 7th busy cycle
        mode = 2'b10; high_len = 8'd1; low_len = 8'd1; start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step("cont", 1'(i % 2), 1, 0, 0, 8'(i / 2));
            start = 1'b0;
        end
        stop = 1'b1;
        step("cont_abort", 0, 0, 0, 1, 8'd3);
        step("cont_after", 0, 0, 0, 0, 8'd3);
        step("stop_idle", 0, 0, 0, 0, 8'd3);
        stop = 1'b0;

        // zero-valued config latched as 1
        mode = 2'b01; high_len = 8'd0; low_len = 8'd0; count = 8'd0; start = 1'b1;
        step("zero", 1, 1, 0, 0, 8'd0);
        start = 1'b0;
        step("zero_done", 0, 0, 1, 0, 8'd1);
        step("zero_idle", 0, 0, 0, 0, 8'd1);

        // start together with stop in idle is accepted
        mode = 2'b00; high_len = 8'd1; start = 1'b1; stop = 1'b1;
        step("start_stop", 1, 1, 0, 0, 8'd0);
        start = 1'b0; stop = 1'b0;
        step("start_stop_done", 0, 0, 1, 0, 8'd1);

        // burst of 4 with a start re-pulsed mid-sequence (ignored, config changes ignored too)
        mode = 2'b01; high_len = 8'd1; low_len = 8'd1; count = 8'd4; start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step("restart_ign", 1'(i % 2), 1, 0, 0, 8'(i / 2));
            start = (i == 2);
            if (i == 2) begin
                mode = 2'b00; high_len = 8'd9; count = 8'd1;
            end
        end
        step("restart_done", 0, 0, 1, 0, 8'd4);

        // back-to-back: start held through done gives exactly one low cycle
        mode = 2'b00; high_len = 8'd2; start = 1'b1;
        step("b2b_a", 1, 1, 0, 0, 8'd0);
        step("b2b_a", 1, 1, 0, 0, 8'd0);
        step("b2b_a_done", 0, 0, 1, 0, 8'd1);
        step("b2b_b", 1, 1, 0, 0, 8'd0);
        step("b2b_b", 1, 1, 0, 0, 8'd0);
        start = 1'b0;
        step("b2b_b_done", 0, 0, 1, 0, 8'd1);
        step("b2b_idle", 0, 0, 0, 0, 8'd1);

        // asynchronous reset mid-burst
        mode = 2'b01; high_len = 8'd3; low_len = 8'd2; count = 8'd5; start = 1'b1;
        step("rst_burst", 1, 1, 0, 0, 8'd0);
        start = 1'b0;
        step("rst_burst", 1, 1, 0, 0, 8'd0);
        step("rst_burst", 1, 1, 0, 0, 8'd0);
        step("rst_burst", 0, 1, 0, 0, 8'd1);
        step("rst_burst", 0, 1, 0, 0, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check_now("async_rst", 8'd0);
        @(posedge clock);
        #1;
        check_now("rst_held", 8'd0);
        #2;
        reset = 1'b0;
        step("post_rst", 0, 0, 0, 0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Synthesisable, parametrised successor to the fixed-delay test pulse generators.
- Produces a single pulse, a burst of N pulses, or a continuous pulse train on one output.
- High and low widths are counted in clock cycles and are configurable at run time.
- Used as a stimulus/strobe source in benches and as a timing strobe inside designs; start/stop handshake with busy/done/aborted status.

Parameters:
W, 8, width of high_len/low_len phase counters (max phase = 2^W-1 cycles)
CW, 8, width of count input and pulse_cnt output (max burst = 2^CW-1 pulses)

Ports:
clock  input  1  system clock, all state changes on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when idle (busy=0)
stop  input  1  abort request; effective only when busy=1
mode  input  2  00 single, 01 burst, 10 continuous, 11 treated as single
high_len  input  W  high-phase length in cycles, latched on start
low_len  input  W  low-phase length in cycles, latched on start
count  input  CW  pulses per burst (mode 01), latched on start
signal  output  1  generated pulse output (registered)
busy  output  1  high while a sequence is in progress
done  output  1  one-cycle strobe on natural completion
aborted  output  1  one-cycle strobe when a sequence is ended by stop
pulse_cnt  output  CW  completed high phases since last accepted start

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): state IDLE; signal, busy, done and aborted = 0; pulse_cnt = 0; latched config = 0.
- States: IDLE, HIGH, LOW. All outputs are registered.
- Start acceptance: in IDLE, start=1 at edge E0:
  - latch mode/high_len/low_len/count; zero-valued lengths or count are latched as 1;
  - clear pulse_cnt; enter HIGH.
  - signal=1 and busy=1 from E0 onward: one cycle of latency from start to signal.
- HIGH: signal=1 for exactly high_len cycles. At its end, pulse_cnt increments (wraps at 2^CW silently). Then:
  - single: go to IDLE.
  - burst: go to IDLE if pulse_cnt+1 == count, else go to LOW.
  - continuous: always go to LOW.
- LOW: signal=0 for exactly low_len cycles, then go to HIGH.
- Trailing low: the final pulse of single/burst is not followed by a LOW phase.
- Natural completion (HIGH to IDLE): in the same cycle signal=0, busy=0 and done=1; done clears the next cycle.
- Back-to-back starts: start sampled during the done cycle is accepted, giving exactly one low cycle between sequences.
- Stop: stop=1 at an edge while in HIGH or LOW:
  - next state IDLE; signal=0, busy=0, aborted=1 for one cycle, done stays 0;
  - pulse_cnt holds (a truncated high phase is not counted).
  - stop in IDLE is ignored.
  - start+stop together in IDLE: start is accepted.
- Busy-time inputs: start while busy is ignored. Config inputs are don't-care except at the start-acceptance edge.
- Illegal states (unreachable encodings) return to IDLE.
- Period in continuous mode: high_len+low_len cycles. Burst busy time: count*high_len + (count-1)*low_len cycles.

Test Plan:
- Single: reset, mode=00, high_len=3, start pulsed 1 cycle -> signal=1 for cycles 1-3; cycle 4 signal=0, done=1, busy=0; pulse_cnt=1.
- Burst: mode=01, high_len=2, low_len=2, count=3 -> signal 1,1,0,0,1,1,0,0,1,1, then done=1; busy 10 cycles; pulse_cnt=3; no trailing low phase.
- Continuous with stop: mode=10, high_len=1, low_len=1, stop at 7th busy cycle -> signal toggles 1,0,1,0,1,0,1 then 0; aborted=1 for one cycle; done=0; pulse_cnt=3 (truncated pulse not counted).
- Zero config and ignored start: high_len=0, low_len=0, count=0, mode=01 -> one 1-cycle pulse then done; start re-pulsed mid-sequence of a count=4 burst -> no restart, pulse_cnt ends at 4.
- Back-to-back and reset: start held high through done -> second sequence begins after exactly one low cycle; assert reset asynchronously (between edges) mid-burst -> signal/busy/pulse_cnt go to 0 immediately, no done/aborted strobe.
